// File: rtl/accu_pkg.sv
// Shared constants and types for the 4-sample accumulate path (splitter and accumulator).
package accu_pkg;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned GROUP  = 4;
  localparam int unsigned IDX_W  = $clog2(GROUP);
  localparam int unsigned WORD_W = BYTE_W * GROUP;
  localparam int unsigned SUM_W  = BYTE_W + IDX_W;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(GROUP - 1);

  typedef logic [BYTE_W-1:0] sample_t;
  typedef logic [WORD_W-1:0] word_t;
  typedef logic [SUM_W-1:0]  sum_t;

  typedef enum logic {
    StIdle,
    StSend
  } split_state_e;

  function automatic sample_t get_sample(input word_t word, input logic [IDX_W-1:0] idx);
    return word[BYTE_W*int'(idx) +: BYTE_W];
  endfunction

endpackage

// File: rtl/accu_sum_tree.sv
// Combinational GROUP-input adder: unsigned sum of all samples of one packed word.
module accu_sum_tree
  import accu_pkg::*;
(
  input  logic [WORD_W-1:0] i_word,
  output logic [SUM_W-1:0]  o_sum
);

  // SUM_W is wide enough that the sum of GROUP full-scale samples never overflows.
  always_comb begin
    o_sum = '0;
    for (int i = 0; i < GROUP; i++) begin
      o_sum = o_sum + sum_t'(i_word[i*BYTE_W +: BYTE_W]);
    end
  end

endmodule

// File: rtl/accu_splitter.sv
// Word-to-sample splitter: one packed word in, GROUP samples out, one per transfer.
// Optional word checksum output enabled by defining ACCU_SPLITTER_CHECKSUM_EN.
module accu_splitter
  import accu_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [WORD_W-1:0] data_in,
  input  logic              valid_in,
  output logic              ready_in,
  output logic [BYTE_W-1:0] data_out,
  output logic              valid_out,
  input  logic              ready_out,
  output logic              last_out
`ifdef ACCU_SPLITTER_CHECKSUM_EN
  ,
  output logic [SUM_W-1:0]  sum_out
`endif
);

  split_state_e     r_state;
  logic [IDX_W-1:0] r_idx;
  word_t            r_word;

  logic w_busy;
  logic w_last;
  logic w_accept;

  assign w_busy   = (r_state == StSend);
  assign w_last   = w_busy && (r_idx == LAST_IDX);
  // Only taking a new word on the final sample transfer keeps r_word intact mid-word.
  assign ready_in = !w_busy || (ready_out && w_last);
  assign w_accept = valid_in && ready_in;

  assign valid_out = w_busy;
  assign last_out  = w_last;
  assign data_out  = get_sample(r_word, r_idx);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
      r_idx   <= '0;
      r_word  <= '0;
    end else begin
      case (r_state)
        StIdle: begin
          if (w_accept) begin
            r_word  <= data_in;
            r_idx   <= '0;
            r_state <= StSend;
          end
        end
        StSend: begin
          if (ready_out) begin
            if (w_last) begin
              r_idx <= '0;
              if (w_accept) begin
                r_word <= data_in;
              end else begin
                r_state <= StIdle;
              end
            end else begin
              r_idx <= r_idx + 1'b1;
            end
          end
        end
        default: begin
          r_state <= StIdle;
          r_idx   <= '0;
        end
      endcase
    end
  end

`ifdef ACCU_SPLITTER_CHECKSUM_EN
  logic [SUM_W-1:0] w_sum;
  logic [SUM_W-1:0] r_sum;

  accu_sum_tree u_sum_tree (
    .i_word (data_in),
    .o_sum  (w_sum)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sum <= '0;
    end else if (w_accept) begin
      r_sum <= w_sum;
    end
  end

  assign sum_out = r_sum;
`endif

endmodule
